// File: rtl/fa_serial_sched_if.sv
// rtl/fa_serial_sched_if.sv - requester, result and adder-cell signals of fa_serial_sched
interface fa_serial_sched_if #(
    parameter int N = 8
);
    logic         req0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         cin0;
    logic         req1;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic         cin1;
    logic [1:0]   gnt;
    logic         busy;
    logic         done;
    logic         done_id;
    logic [N-1:0] sum;
    logic         cout;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sout;
    logic         fa_cout;

    // Environment side: requesters plus the analog cell outputs.
    modport master (
        output req0, a0, b0, cin0, req1, a1, b1, cin1, fa_sout, fa_cout,
        input  gnt, busy, done, done_id, sum, cout, fa_a, fa_b, fa_cin
    );

    // Scheduler side.
    modport slave (
        input  req0, a0, b0, cin0, req1, a1, b1, cin1, fa_sout, fa_cout,
        output gnt, busy, done, done_id, sum, cout, fa_a, fa_b, fa_cin
    );
endinterface

// File: rtl/fa_serial_sched.sv
// rtl/fa_serial_sched.sv - round-robin bit-serial scheduler for one shared full-adder cell
module fa_serial_sched #(
    parameter int N      = 8,
    parameter int SETTLE = 3
) (
    input  logic             clk,
    input  logic             rst,
    fa_serial_sched_if.slave bus
);
    localparam int SET = (SETTLE < 1) ? 1 : SETTLE;
    localparam int CW  = (SET > 1) ? $clog2(SET) : 1;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SET - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t        state, state_nx;
    logic [N-1:0]  op_a, op_b, sum_r, sum_nx, sum_o;
    logic          cout_o;
    logic          lp;
    logic          pick, any_req;
    logic [IW-1:0] idx, idx_inc;
    logic [CW-1:0] cnt;
    logic          fa_a_r, fa_b_r, fa_cin_r;
    logic [1:0]    gnt_o;
    logic          busy_o, done_o, done_id_o;

    // Arbitration: a lone requester wins; on a tie the side not granted last wins.
    assign any_req = bus.req0 | bus.req1;
    assign pick    = (bus.req0 & bus.req1) ? ~lp : bus.req1;
    assign idx_inc = idx + IDX_ONE;

    // Result vector with the bit currently returned by the cell merged in.
    always_comb begin
        sum_nx      = sum_r;
        sum_nx[idx] = bus.fa_sout;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs; lp doubles as the owner of the running job.
    always_comb begin
        state_nx  = state;
        busy_o    = (state != IDLE);
        done_o    = (state == DONE);
        done_id_o = (state == DONE) & lp;
        gnt_o     = 2'b00;
        if (state != IDLE) begin
            gnt_o = lp ? 2'b10 : 2'b01;
        end
        case (state)
            IDLE:    if (any_req) state_nx = DRIVE;
            DRIVE:   if (cnt == CNT_LAST) state_nx = SAMPLE;
            SAMPLE:  state_nx = (idx == IDX_LAST) ? DONE : DRIVE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, cell drive, settle counting and result reassembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            lp       <= 1'b1;
            idx      <= '0;
            cnt      <= '0;
            sum_r    <= '0;
            sum_o    <= '0;
            cout_o   <= 1'b0;
            fa_a_r   <= 1'b0;
            fa_b_r   <= 1'b0;
            fa_cin_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lp       <= pick;
                        op_a     <= pick ? bus.a1 : bus.a0;
                        op_b     <= pick ? bus.b1 : bus.b0;
                        idx      <= '0;
                        cnt      <= '0;
                        fa_a_r   <= pick ? bus.a1[0] : bus.a0[0];
                        fa_b_r   <= pick ? bus.b1[0] : bus.b0[0];
                        fa_cin_r <= pick ? bus.cin1 : bus.cin0;
                    end
                end
                DRIVE: begin
                    if (cnt != CNT_LAST) cnt <= cnt + CNT_ONE;
                end
                SAMPLE: begin
                    sum_r <= sum_nx;
                    if (idx == IDX_LAST) begin
                        sum_o    <= sum_nx;
                        cout_o   <= bus.fa_cout;
                        fa_a_r   <= 1'b0;
                        fa_b_r   <= 1'b0;
                        fa_cin_r <= 1'b0;
                    end else begin
                        idx      <= idx_inc;
                        cnt      <= '0;
                        fa_a_r   <= op_a[idx_inc];
                        fa_b_r   <= op_b[idx_inc];
                        // The cell's carry-out is the next bit's carry-in.
                        fa_cin_r <= bus.fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt     = gnt_o;
    assign bus.busy    = busy_o;
    assign bus.done    = done_o;
    assign bus.done_id = done_id_o;
    assign bus.sum     = sum_o;
    assign bus.cout    = cout_o;
    assign bus.fa_a    = fa_a_r;
    assign bus.fa_b    = fa_b_r;
    assign bus.fa_cin  = fa_cin_r;
endmodule

// File: tb/tb_fa_serial_sched.sv
// tb/tb_fa_serial_sched.sv - self-checking bench for fa_serial_sched
module tb_fa_serial_sched;
    localparam int N      = 8;
    localparam int SETTLE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fa_serial_sched_if #(.N(N)) bus ();

    fa_serial_sched #(.N(N), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural adder cell with a two-cycle output delay; cell_bad inverts Sout.
    logic s1 = 1'b0, s2 = 1'b0, c1 = 1'b0, c2 = 1'b0;
    logic cell_bad = 1'b0;
    always @(posedge clk) begin
        s1 <= bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
        c1 <= (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_cin) | (bus.fa_b & bus.fa_cin);
        s2 <= s1 ^ cell_bad;
        c2 <= c1;
    end
    assign bus.fa_sout = s2;
    assign bus.fa_cout = c2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] opa [2];
    logic [7:0] opb [2];
    logic       opc [2];
    int         lp_m = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic c, input logic bad);
        logic [8:0] r;
        r = {1'b0, a} + {1'b0, b} + {8'b0, c};
        if (bad) r[7:0] = ~r[7:0];
        return r;
    endfunction

    function automatic logic cin_at(input logic [7:0] a, input logic [7:0] b,
                                    input logic c, input int i);
        int m, t;
        m = 1 << i;
        t = (int'(a) % m) + (int'(b) % m) + int'(c);
        return ((t >> i) & 1) != 0;
    endfunction

    // Runs one or two simultaneous requests to completion and checks each result.
    task automatic serve(input logic r0, input logic r1,
                         output logic [7:0] first_sum, output logic first_cout);
        int order [2];
        int njobs, k, n, s, last_done, cur, j, bi;
        logic ok;
        logic [2:0] prev_fa, fa_now;
        logic [1:0] prev_gnt;
        logic [8:0] e;
        first_sum  = '0;
        first_cout = 1'b0;
        @(posedge clk);
        #1;
        if (r0 && r1) begin
            order[0] = (lp_m == 1) ? 0 : 1;
            order[1] = 1 - order[0];
            njobs    = 2;
        end else begin
            order[0] = r1 ? 1 : 0;
            order[1] = order[0];
            njobs    = 1;
        end
        lp_m = order[njobs-1];
        bus.a0 = opa[0]; bus.b0 = opb[0]; bus.cin0 = opc[0];
        bus.a1 = opa[1]; bus.b1 = opb[1]; bus.cin1 = opc[1];
        bus.req0 = r0;
        bus.req1 = r1;
        k = 0; n = 0; s = 0; last_done = 0; cur = order[0]; ok = 1'b1;
        prev_fa = '0; prev_gnt = '0;
        while (k < njobs && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            fa_now = {bus.fa_a, bus.fa_b, bus.fa_cin};
            if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
                s   = n;
                ok  = 1'b1;
                cur = order[k];
                chk("grant", bus.gnt, (cur == 1) ? 2 : 1);
            end
            if (bus.gnt != 2'b00 && !bus.done) begin
                j  = n - s;
                bi = j / 4;
                if ((j % 4) != 0 && fa_now != prev_fa) ok = 1'b0;
                if (bi > 7) ok = 1'b0;
                else if (fa_now != {opa[cur][bi], opb[cur][bi],
                                    cin_at(opa[cur], opb[cur], opc[cur], bi)}) ok = 1'b0;
            end
            prev_fa  = fa_now;
            prev_gnt = bus.gnt;
            if (bus.gnt[0] && bus.req0) begin
                bus.req0 = 1'b0;
                bus.a0 = 8'($urandom); bus.b0 = 8'($urandom); bus.cin0 = 1'($urandom);
            end
            if (bus.gnt[1] && bus.req1) begin
                bus.req1 = 1'b0;
                bus.a1 = 8'($urandom); bus.b1 = 8'($urandom); bus.cin1 = 1'($urandom);
            end
            if (bus.done) begin
                e = ref_sum(opa[cur], opb[cur], opc[cur], cell_bad);
                chk("done_id", bus.done_id, cur);
                chk("sum", bus.sum, e[7:0]);
                chk("cout", bus.cout, e[8]);
                chk("fa_drive", ok, 1);
                chk("fa_zero_done", fa_now, 0);
                if (k == 0) begin
                    chk("latency", n, 33);
                    first_sum  = bus.sum;
                    first_cout = bus.cout;
                end else begin
                    chk("b2b_gap", n - last_done, 34);
                end
                last_done = n;
                k++;
            end
        end
        if (k < njobs) chk("serve_timeout", k, njobs);
        e = ref_sum(opa[order[njobs-1]], opb[order[njobs-1]], opc[order[njobs-1]], cell_bad);
        @(posedge clk);
        #1;
        chk("sum_held", {bus.cout, bus.sum}, e);
        chk("idle_busy", {bus.busy, bus.gnt, bus.done}, 0);
    endtask

    typedef struct {
        logic       r0, r1;
        logic [7:0] a0, b0;
        logic       c0;
        logic [7:0] a1, b1;
        logic       c1;
        logic       bad;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] fs;
    logic       fc;
    logic [1:0] rr;
    logic [8:0] e;
    int         n, got, last, exp_id;

    initial begin
        bus.req0 = 0; bus.a0 = 0; bus.b0 = 0; bus.cin0 = 0;
        bus.req1 = 0; bus.a1 = 0; bus.b1 = 0; bus.cin1 = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_flags", {bus.busy, bus.done, bus.done_id}, 0);
        chk("rst_result", {bus.cout, bus.sum}, 0);
        chk("rst_fa", {bus.fa_a, bus.fa_b, bus.fa_cin}, 0);
        @(negedge clk);
        rst = 1'b0;

        //           r0 r1  a0     b0     c0 a1     b1     c1 bad exp_sum cout
        tbl[0] = '{1, 0, 8'h5A, 8'h3C, 0, 8'h00, 8'h00, 0, 0, 8'h96, 0};
        tbl[1] = '{0, 1, 8'h00, 8'h00, 0, 8'hFF, 8'h01, 0, 0, 8'h00, 1};
        tbl[2] = '{0, 1, 8'h00, 8'h00, 0, 8'hFF, 8'hFF, 1, 0, 8'hFF, 1};
        tbl[3] = '{1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0};
        tbl[4] = '{1, 0, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 0, 0, 8'hFF, 1};
        tbl[5] = '{0, 1, 8'h00, 8'h00, 0, 8'h80, 8'h80, 0, 0, 8'h00, 1};
        tbl[6] = '{1, 0, 8'h5A, 8'h3C, 0, 8'h00, 8'h00, 0, 1, 8'h69, 0};
        tbl[7] = '{1, 1, 8'h01, 8'h02, 0, 8'h10, 8'h20, 1, 0, 8'h31, 0};
        for (int i = 0; i < 8; i++) begin
            opa[0] = tbl[i].a0; opb[0] = tbl[i].b0; opc[0] = tbl[i].c0;
            opa[1] = tbl[i].a1; opb[1] = tbl[i].b1; opc[1] = tbl[i].c1;
            cell_bad = tbl[i].bad;
            serve(tbl[i].r0, tbl[i].r1, fs, fc);
            chk("tbl_sum", fs, tbl[i].exp_sum);
            chk("tbl_cout", fc, tbl[i].exp_cout);
            cell_bad = 1'b0;
        end

        // Reset asserted during bit 4 of a job
        bus.a0 = 8'hA5; bus.b0 = 8'h5A; bus.cin0 = 1'b1; bus.req0 = 1'b1;
        n = 0;
        while (n < 18) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.gnt[0]) bus.req0 = 1'b0;
        end
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", bus.gnt, 0);
        chk("mid_rst_flags", {bus.busy, bus.done, bus.done_id}, 0);
        chk("mid_rst_result", {bus.cout, bus.sum}, 0);
        chk("mid_rst_fa", {bus.fa_a, bus.fa_b, bus.fa_cin}, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("mid_rst_nodone", bus.done, 0);
        end
        @(negedge clk);
        rst  = 1'b0;
        lp_m = 1;

        // Both rise together after reset: 0 first, then 1
        opa[0] = 8'h0F; opb[0] = 8'hF1; opc[0] = 1'b0;
        opa[1] = 8'hC8; opb[1] = 8'h64; opc[1] = 1'b1;
        serve(1'b1, 1'b1, fs, fc);

        // Both held high for four jobs: grants alternate
        opa[0] = 8'h3C; opb[0] = 8'hC3; opc[0] = 1'b1;
        opa[1] = 8'h77; opb[1] = 8'h11; opc[1] = 1'b0;
        @(posedge clk);
        #1;
        bus.a0 = opa[0]; bus.b0 = opb[0]; bus.cin0 = opc[0];
        bus.a1 = opa[1]; bus.b1 = opb[1]; bus.cin1 = opc[1];
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        exp_id = (lp_m == 1) ? 0 : 1;
        got = 0; n = 0; last = 0;
        while (got < 4 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) begin
                chk("alt_id", bus.done_id, exp_id);
                e = ref_sum(opa[exp_id], opb[exp_id], opc[exp_id], 1'b0);
                chk("alt_result", {bus.cout, bus.sum}, e);
                if (got > 0) chk("alt_gap", n - last, 34);
                last   = n;
                lp_m   = exp_id;
                exp_id = 1 - exp_id;
                got++;
                if (got == 4) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
        end
        if (got < 4) chk("alt_timeout", got, 4);
        repeat (2) @(posedge clk);
        #1;
        chk("alt_idle", bus.busy, 0);

        // Randomized jobs against the arithmetic reference
        for (int it = 0; it < 20; it++) begin
            rr = 2'($urandom_range(1, 3));
            opa[0] = 8'($urandom); opb[0] = 8'($urandom); opc[0] = 1'($urandom);
            opa[1] = 8'($urandom); opb[1] = 8'($urandom); opc[1] = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            serve(rr[0], rr[1], fs, fc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
